// File: rtl/proj_pkg.sv
// Shared types and width helpers for the Q/K/V projection engine.
package proj_pkg;

  typedef enum logic [1:0] {
    MODE_Q   = 2'd0,
    MODE_K   = 2'd1,
    MODE_V   = 2'd2,
    MODE_BAD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    TGT_IN   = 2'd0,
    TGT_W    = 2'd1,
    TGT_O    = 2'd2,
    TGT_NONE = 2'd3
  } tgt_e;

  function automatic int clog2c(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int opw_f(input int lanes, input int data_w, input int acc_w);
    return (lanes * data_w) / acc_w;
  endfunction

  function automatic int in_aw_f(input int n_tok, input int in_words);
    return clog2c(n_tok * in_words);
  endfunction

  function automatic int w_aw_f(input int n_modes, input int n_out, input int in_words);
    return clog2c(n_modes * n_out * in_words);
  endfunction

  function automatic int o_aw_f(input int n_tok, input int n_out, input int opw);
    return clog2c((n_tok * n_out) / opw);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/proj_dot.sv
// Combinational LANES-wide signed dot product, sign-extended to ACC_W.
module proj_dot #(
  parameter int LANES  = 16,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic [LANES*DATA_W-1:0] a_i,
  input  logic [LANES*DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]        dot_o
);

  logic signed [2*DATA_W-1:0] prod [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_mul
    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;
    assign a_ext   = (2*DATA_W)'($signed(a_i[i*DATA_W +: DATA_W]));
    assign b_ext   = (2*DATA_W)'($signed(b_i[i*DATA_W +: DATA_W]));
    assign prod[i] = a_ext * b_ext;
  end

  always_comb begin
    dot_o = '0;
    for (int i = 0; i < LANES; i++) begin
      dot_o = dot_o + ACC_W'(prod[i]);
    end
  end

endmodule

// File: rtl/proj_engine.sv
// Q/K/V projection engine: sequences input/weight SRAM reads, accumulates dot
// products, packs results into output words, and arbitrates host SRAM access.
module proj_engine
  import proj_pkg::*;
#(
  parameter int LANES    = 16,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int N_TOK    = 32,
  parameter int IN_WORDS = 4,
  parameter int N_OUT    = 16,
  parameter int N_MODES  = 3,
  localparam int WORD_W  = LANES * DATA_W,
  localparam int OPW     = opw_f(LANES, DATA_W, ACC_W),
  localparam int IN_AW   = in_aw_f(N_TOK, IN_WORDS),
  localparam int W_AW    = w_aw_f(N_MODES, N_OUT, IN_WORDS),
  localparam int O_AW    = o_aw_f(N_TOK, N_OUT, OPW),
  localparam int H_AW    = max3(IN_AW, W_AW, O_AW)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              in_ceb,
  output logic              in_web,
  output logic [IN_AW-1:0]  in_addr,
  output logic [WORD_W-1:0] in_din,
  input  logic [WORD_W-1:0] in_dout,
  output logic              w_ceb,
  output logic              w_web,
  output logic [W_AW-1:0]   w_addr,
  output logic [WORD_W-1:0] w_din,
  input  logic [WORD_W-1:0] w_dout,
  output logic              o_ceb,
  output logic              o_web,
  output logic [O_AW-1:0]   o_addr,
  output logic [WORD_W-1:0] o_din,
  input  logic [WORD_W-1:0] o_dout,
  input  logic              host_req,
  input  logic [1:0]        host_tgt,
  input  logic              host_we,
  input  logic [H_AW-1:0]   host_addr,
  input  logic [WORD_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [WORD_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid
);

  localparam int TW = clog2c(N_TOK);
  localparam int JW = clog2c(N_OUT);
  localparam int KW = clog2c(IN_WORDS);
  localparam int PW = clog2c(OPW);

  if ((N_OUT * N_TOK) % OPW != 0) begin : g_cfg_chk
    $error("proj_engine: N_OUT*N_TOK must be a multiple of OPW");
  end

  state_e            state_q;
  mode_e             mode_q;
  logic              busy_q, done_q, err_q, drain_q;
  logic [TW-1:0]     t_q, t_d;
  logic [JW-1:0]     j_q, j_d;
  logic [KW-1:0]     k_q, k_d;
  logic              last_d;
  logic              in_ceb_q, w_ceb_q, o_ceb_q, out_valid_q;
  logic [IN_AW-1:0]  in_addr_q, in_addr_d;
  logic [W_AW-1:0]   w_addr_q, w_addr_d;
  logic [O_AW-1:0]   o_addr_q, ocnt_q;
  logic [WORD_W-1:0] pack_q, pack_d, o_din_q;
  logic [ACC_W-1:0]  acc_q, acc_d, dot;
  logic              rd_vld_q;
  logic [KW-1:0]     rd_k_q;
  logic [PW-1:0]     pcnt_q;
  logic              hrv_q;
  tgt_e              htgt_q, tgt;
  logic              host_ok, h_in, h_w, h_o;

  proj_dot #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W)) u_dot (
    .a_i   (in_dout),
    .b_i   (w_dout),
    .dot_o (dot)
  );

  // Loop order t, j, k (k innermost); last_d flags the final issue.
  always_comb begin
    k_d    = k_q + 1'b1;
    j_d    = j_q;
    t_d    = t_q;
    last_d = 1'b0;
    if (k_q == KW'(IN_WORDS - 1)) begin
      k_d = '0;
      j_d = j_q + 1'b1;
      if (j_q == JW'(N_OUT - 1)) begin
        j_d = '0;
        t_d = t_q + 1'b1;
        last_d = (t_q == TW'(N_TOK - 1));
      end
    end
    in_addr_d = IN_AW'(int'(t_d) * IN_WORDS + int'(k_d));
    w_addr_d  = W_AW'((int'(mode_q) * N_OUT + int'(j_d)) * IN_WORDS + int'(k_d));
    acc_d     = (rd_k_q == '0) ? dot : acc_q + dot;
    pack_d    = {acc_d, pack_q[WORD_W-1:ACC_W]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_Q;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      drain_q     <= 1'b0;
      t_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      in_ceb_q    <= 1'b1;
      w_ceb_q     <= 1'b1;
      o_ceb_q     <= 1'b1;
      out_valid_q <= 1'b0;
      in_addr_q   <= '0;
      w_addr_q    <= '0;
      o_addr_q    <= '0;
      ocnt_q      <= '0;
      pack_q      <= '0;
      o_din_q     <= '0;
      acc_q       <= '0;
      rd_vld_q    <= 1'b0;
      rd_k_q      <= '0;
      pcnt_q      <= '0;
      hrv_q       <= 1'b0;
      htgt_q      <= TGT_IN;
    end else begin
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      o_ceb_q     <= 1'b1;
      rd_vld_q    <= 1'b0;
      hrv_q       <= host_ok && !host_we && (tgt != TGT_NONE);
      htgt_q      <= tgt;

      // Read data lands one cycle after issue; a finished sum packs, a full pack writes.
      if (rd_vld_q) begin
        acc_q <= acc_d;
        if (rd_k_q == KW'(IN_WORDS - 1)) begin
          pack_q <= pack_d;
          pcnt_q <= pcnt_q + 1'b1;
          if (pcnt_q == PW'(OPW - 1)) begin
            pcnt_q      <= '0;
            o_ceb_q     <= 1'b0;
            o_din_q     <= pack_d;
            o_addr_q    <= ocnt_q;
            ocnt_q      <= ocnt_q + 1'b1;
            out_valid_q <= 1'b1;
          end
        end
      end

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (mode_e'(mode) == MODE_BAD) begin
              err_q <= 1'b1;
            end else begin
              state_q   <= S_RUN;
              busy_q    <= 1'b1;
              mode_q    <= mode_e'(mode);
              t_q       <= '0;
              j_q       <= '0;
              k_q       <= '0;
              in_ceb_q  <= 1'b0;
              w_ceb_q   <= 1'b0;
              in_addr_q <= '0;
              w_addr_q  <= W_AW'(int'(mode) * N_OUT * IN_WORDS);
              ocnt_q    <= '0;
              pcnt_q    <= '0;
            end
          end
        end
        S_RUN: begin
          rd_vld_q <= 1'b1;
          rd_k_q   <= k_q;
          t_q      <= t_d;
          j_q      <= j_d;
          k_q      <= k_d;
          if (last_d) begin
            in_ceb_q <= 1'b1;
            w_ceb_q  <= 1'b1;
            drain_q  <= 1'b0;
            state_q  <= S_DRAIN;
          end else begin
            in_addr_q <= in_addr_d;
            w_addr_q  <= w_addr_d;
          end
        end
        S_DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Host owns the SRAM pins only in an IDLE cycle without a start request.
  assign tgt      = tgt_e'(host_tgt);
  assign host_ok  = !rst && (state_q == S_IDLE) && host_req && !start;
  assign h_in     = host_ok && (tgt == TGT_IN);
  assign h_w      = host_ok && (tgt == TGT_W);
  assign h_o      = host_ok && (tgt == TGT_O);
  assign host_gnt = host_ok;

  assign in_ceb  = h_in ? 1'b0 : in_ceb_q;
  assign in_web  = h_in ? ~host_we : 1'b1;
  assign in_addr = h_in ? host_addr[IN_AW-1:0] : in_addr_q;
  assign in_din  = h_in ? host_wdata : '0;

  assign w_ceb   = h_w ? 1'b0 : w_ceb_q;
  assign w_web   = h_w ? ~host_we : 1'b1;
  assign w_addr  = h_w ? host_addr[W_AW-1:0] : w_addr_q;
  assign w_din   = h_w ? host_wdata : '0;

  assign o_ceb   = h_o ? 1'b0 : o_ceb_q;
  assign o_web   = h_o ? ~host_we : o_ceb_q;
  assign o_addr  = h_o ? host_addr[O_AW-1:0] : o_addr_q;
  assign o_din   = h_o ? host_wdata : o_din_q;

  always_comb begin
    host_rdata = '0;
    if (hrv_q) begin
      case (htgt_q)
        TGT_IN:  host_rdata = in_dout;
        TGT_W:   host_rdata = w_dout;
        TGT_O:   host_rdata = o_dout;
        default: host_rdata = '0;
      endcase
    end
  end

  assign host_rvalid = hrv_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign out_data    = o_din_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_proj_engine.sv
// Directed self-checking bench for proj_engine with behavioural SRAM models.
module tb_proj_engine;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   mode;
  logic         busy, done, err;
  logic         in_ceb, in_web, w_ceb, w_web, o_ceb, o_web;
  logic [6:0]   in_addr, o_addr;
  logic [7:0]   w_addr;
  logic [127:0] in_din, in_dout, w_din, w_dout, o_din, o_dout;
  logic         host_req, host_we, host_gnt, host_rvalid, out_valid;
  logic [1:0]   host_tgt;
  logic [7:0]   host_addr;
  logic [127:0] host_wdata, host_rdata, out_data;

  logic [127:0] in_mem [0:127];
  logic [127:0] w_mem  [0:255];
  logic [127:0] o_mem  [0:127];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!in_ceb) begin
      if (!in_web) in_mem[in_addr] <= in_din;
      else         in_dout <= in_mem[in_addr];
    end
    if (!w_ceb) begin
      if (!w_web) w_mem[w_addr] <= w_din;
      else        w_dout <= w_mem[w_addr];
    end
    if (!o_ceb) begin
      if (!o_web) o_mem[o_addr] <= o_din;
      else        o_dout <= o_mem[o_addr];
    end
  end

  proj_engine dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy), .done(done), .err(err),
    .in_ceb(in_ceb), .in_web(in_web), .in_addr(in_addr), .in_din(in_din), .in_dout(in_dout),
    .w_ceb(w_ceb), .w_web(w_web), .w_addr(w_addr), .w_din(w_din), .w_dout(w_dout),
    .o_ceb(o_ceb), .o_web(o_web), .o_addr(o_addr), .o_din(o_din), .o_dout(o_dout),
    .host_req(host_req), .host_tgt(host_tgt), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .out_data(out_data), .out_valid(out_valid)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Input row for the second pattern: element k = k-32.
  function automatic logic [127:0] x2_word(input int kw);
    logic [127:0] w;
    for (int l = 0; l < 16; l++) w[l*8 +: 8] = 8'(kw * 16 + l - 32);
    return w;
  endfunction

  // K weight row j: element 0 = j, everything else zero.
  function automatic logic [127:0] wk_word(input int j, input int kw);
    logic [127:0] w;
    w = '0;
    if (kw == 0) w[7:0] = 8'(j);
    return w;
  endfunction

  // kind 1: all-ones pattern (64 everywhere); kind 2: out[t][j] = -32*j.
  function automatic logic [127:0] exp_word(input int kind, input int n);
    logic [127:0] w;
    int j;
    for (int e = 0; e < 4; e++) begin
      j = (n % 4) * 4 + e;
      w[e*32 +: 32] = (kind == 1) ? 32'd64 : 32'(-32 * j);
    end
    return w;
  endfunction

  task automatic run_job(input logic [1:0] m, input int kind, input bit hold_host);
    int s, dcyc, nw, gnt_busy;
    start = 1'b1;
    mode  = m;
    if (hold_host) begin
      host_req = 1'b1; host_tgt = 2'd0; host_we = 1'b0; host_addr = 8'd0;
      #1;
      chk("start_wins_gnt", host_gnt, 1'b0);
    end
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("run_busy", busy, 1'b1);
    chk("run_in_ceb", in_ceb, 1'b0);
    chk("run_w_addr", w_addr, 128'(m * 64));
    nw = 0; dcyc = -1; gnt_busy = 0;
    for (int i = 0; i < 2200 && dcyc < 0; i++) begin
      if (out_valid) begin
        chk("out_data", out_data, exp_word(kind, nw));
        chk("o_addr", o_addr, 128'(nw));
        nw++;
      end
      if (host_gnt) gnt_busy++;
      if (done) dcyc = cyc;
      else @(negedge clk);
    end
    chk("done_latency", 128'(dcyc - s), 128'd2051);
    chk("write_count", 128'(nw), 128'd128);
    if (hold_host) chk("gnt_while_busy", 128'(gnt_busy), 128'd0);
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
  endtask

  initial begin
    int s, bad;
    rst = 1'b1; start = 1'b0; mode = 2'd0;
    host_req = 1'b0; host_tgt = 2'd0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {busy, done, err, host_gnt, host_rvalid, out_valid}, 6'b0);
    chk("rst_ceb_web", {in_ceb, in_web, w_ceb, w_web, o_ceb, o_web}, 6'b111111);
    chk("rst_addr", {in_addr, w_addr, o_addr}, '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_host_rdata", host_rdata, '0);
    rst = 1'b0;

    // All-ones input and Q weights
    host_req = 1'b1; host_we = 1'b1; host_tgt = 2'd0; host_wdata = {16{8'h01}};
    for (int a = 0; a < 128; a++) begin host_addr = 8'(a); @(negedge clk); end
    host_tgt = 2'd1;
    for (int a = 0; a < 64; a++) begin host_addr = 8'(a); @(negedge clk); end
    host_req = 1'b0; host_we = 1'b0;
    run_job(2'd0, 1, 1'b0);

    // Illegal mode
    start = 1'b1; mode = 2'd3;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", err, 1'b1);
    chk("err_busy", busy, 1'b0);
    chk("err_ceb", {in_ceb, w_ceb, o_ceb}, 3'b111);
    @(negedge clk);
    chk("err_clear", err, 1'b0);
    chk("err_busy2", busy, 1'b0);

    // Host write then read of weight address 191
    host_req = 1'b1; host_tgt = 2'd1; host_we = 1'b1; host_addr = 8'd191; host_wdata = {16{8'hA5}};
    #1;
    chk("hw_gnt", host_gnt, 1'b1);
    chk("hw_pins", {w_ceb, w_web, w_addr}, {2'b00, 8'd191});
    @(negedge clk);
    host_we = 1'b0;
    #1;
    chk("hr_pins", {host_gnt, w_ceb, w_web}, 3'b101);
    @(negedge clk);
    host_tgt = 2'd3;
    chk("hr_rvalid", host_rvalid, 1'b1);
    chk("hr_rdata", host_rdata, {16{8'hA5}});
    #1;
    chk("tgt3_gnt", host_gnt, 1'b1);
    chk("tgt3_ceb", {in_ceb, w_ceb, o_ceb}, 3'b111);
    @(negedge clk);
    host_req = 1'b0;
    chk("tgt3_no_rvalid", host_rvalid, 1'b0);

    // Pattern 2: x[k]=k-32, W_K row j = j at element 0
    host_req = 1'b1; host_we = 1'b1; host_tgt = 2'd0;
    for (int a = 0; a < 128; a++) begin
      host_addr = 8'(a); host_wdata = x2_word(a % 4); @(negedge clk);
    end
    host_tgt = 2'd1;
    for (int a = 0; a < 64; a++) begin
      host_addr = 8'(64 + a); host_wdata = wk_word(a / 4, a % 4); @(negedge clk);
    end
    host_req = 1'b0; host_we = 1'b0;
    run_job(2'd1, 2, 1'b0);

    // Reset mid-job
    start = 1'b1; mode = 2'd0;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 1100 && cyc < s + 1000; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ceb", {in_ceb, w_ceb, o_ceb}, 3'b111);
    chk("midrst_busy_done", {busy, done, out_valid}, 3'b000);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!in_ceb || !w_ceb || !o_ceb || done || busy) bad++;
    end
    chk("midrst_quiet", 128'(bad), 128'd0);

    // Start and host request together; host held through the job
    run_job(2'd1, 2, 1'b1);
    chk("gnt_after_done", host_gnt, 1'b1);
    @(negedge clk);
    chk("post_in_rvalid", host_rvalid, 1'b1);
    chk("post_in_rdata", host_rdata, x2_word(0));
    host_tgt = 2'd2; host_addr = 8'd0;
    @(negedge clk);
    host_req = 1'b0;
    chk("post_o_rvalid", host_rvalid, 1'b1);
    chk("post_o_rdata", host_rdata, exp_word(2, 0));
    @(negedge clk);
    chk("post_rvalid_clear", host_rvalid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/proj_engine.md
Name: proj_engine

Overview:
- Parametrised successor of the single-head Q projection datapath.
- Computes out[t][j] = sum_k x[t][k]*W_m[j][k] for one of three weight sets (Q/K/V) selected per job.
- Sequences single-port SRAMs with 1-cycle read latency, packs accumulators into output words and streams them.
- Owns host load/readback arbitration, replacing external init/fin address muxes.

Parameters:
- LANES, 16, signed elements per SRAM word
- DATA_W, 8, element width (signed)
- ACC_W, 32, accumulator / output element width
- N_TOK, 32, tokens per job
- IN_WORDS, 4, words per input row (D_IN = IN_WORDS*LANES)
- N_OUT, 16, outputs per token per mode
- N_MODES, 3, weight sets stored back to back (Q, K, V)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  job request, sampled in IDLE
- mode  in  2  0=Q, 1=K, 2=V, 3 illegal
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- err  out  1  one-cycle pulse when start is rejected
- in_ceb/in_web  out  1  input SRAM chip/write enable, active low
- in_addr  out  IN_AW=clog2(N_TOK*IN_WORDS)  input SRAM address
- in_din  out  LANES*DATA_W  input SRAM write data
- in_dout  in  LANES*DATA_W  input SRAM read data
- w_ceb/w_web/w_addr/w_din/w_dout  as above, W_AW=clog2(N_MODES*N_OUT*IN_WORDS)  weight SRAM
- o_ceb/o_web/o_addr/o_din/o_dout  as above, O_AW=clog2(N_TOK*N_OUT/OPW), OPW=LANES*DATA_W/ACC_W  output SRAM
- host_req  in  1  host access request
- host_tgt  in  2  0=input, 1=weight, 2=output
- host_we  in  1  1=write
- host_addr  in  max AW  host address
- host_wdata  in  LANES*DATA_W  host write data
- host_gnt  out  1  host request accepted this cycle
- host_rdata  out  LANES*DATA_W  read data
- host_rvalid  out  1  host_rdata valid
- out_data  out  LANES*DATA_W  packed word being written
- out_valid  out  1  out_data valid

Behaviour:
- Reset: state IDLE; busy, done, err, host_gnt, host_rvalid, out_valid = 0; all *_ceb and *_web = 1; addresses, *_din, out_data, host_rdata = 0; counters and accumulator cleared. Reset mid-job aborts with no further SRAM access.
- FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE, start with mode<3: latch mode, enter RUN; busy=1 from the next cycle.
- IDLE, start with mode=3: err pulse next cycle, stay IDLE.
- start outside IDLE is ignored.
- RUN issues one read pair per cycle; loop order t (outer), j, k (inner).
  - in_addr = t*IN_WORDS+k.
  - w_addr = (mode*N_OUT+j)*IN_WORDS+k.
  - in_ceb = w_ceb = 0, web = 1.
- Data returns the next cycle. proj_dot forms the LANES-wide signed dot product combinationally.
  - acc <= (k==0 ? dot : acc+dot); wraps mod 2^ACC_W.
- After the k=IN_WORDS-1 update, acc shifts into the pack register; element 0 sits in bits [ACC_W-1:0].
- Once OPW elements are packed, the next cycle writes them:
  - o_ceb = o_web = 0.
  - o_addr = (t*N_OUT+j)/OPW (running word count).
  - o_din = out_data = packed word; out_valid = 1 that cycle only.
- DRAIN covers the last data cycle and the last write. DONE raises done for 1 cycle, then IDLE with busy=0.
- Timing: start accepted in cycle S gives issue cycles S+1..S+T, T = N_TOK*N_OUT*IN_WORDS. Last write in S+T+2, done in S+T+3. Default: done at S+2051, 128 output writes.
- N_OUT*N_TOK must be a multiple of OPW; checked at elaboration.
- Host access: granted only in IDLE with no start that cycle (start wins), host_gnt=1 that cycle.
  - Write: target SRAM ceb = web = 0 with host_addr/host_wdata; addresses truncated to target AW.
  - Read: target ceb = 0, web = 1; host_rvalid=1 next cycle with host_rdata = selected *_dout.
  - host_tgt=3: gnt=1, no access, no rvalid.
  - While busy, host_gnt=0 and the host holds the request.

Decomposition:
- proj_pkg holds:
  - mode_e (MODE_Q/K/V), state_e, host target enum
  - clog2-derived width functions for IN_AW/W_AW/O_AW/OPW
- Sub-module proj_dot: parametrised LANES signed DATA_W multipliers plus adder tree to ACC_W; purely combinational.

Test Plan:
- All x=1, W_Q=1, mode=0 -> every output element 64; 128 out_valid words, each 0x00000040 x4; done at S+2051.
- x[t][k]=k-32, W_K row j all 0 except W[j][0]=j, mode=1 -> out[t][j] = -32*j, e.g. j=3 gives 0xFFFFFFA0.
- start with mode=3 -> err pulse next cycle, busy stays 0, no SRAM ceb activity.
- Host write then read of weight addr 191 with 0xA5.. -> host_rvalid one cycle later with the same data; host_req during a job -> host_gnt=0 until after done.
- rst asserted at cycle S+1000 -> next cycle all ceb=1, busy=0, no done; a new start produces correct full results.
- start and host_req in the same IDLE cycle -> job starts, host_gnt=0; host is granted the cycle after done.
